// File: rtl/drug_placer.sv
// drug_placer: places an edible drug on a free cell of the snake playfield.
// Requests candidates from a random generator, rejects cells occupied by the
// snake body or head, displays the accepted drug and tracks score when eaten.
module drug_placer (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_start,
  input  logic       game_over,
  input  logic       head_step,
  input  logic [4:0] head_x,
  input  logic [4:0] head_y,
  input  logic [4:0] cand_x,
  input  logic [4:0] cand_y,
  input  logic       query_occupied,
  output logic       drug_valid,
  output logic [4:0] query_x,
  output logic [4:0] query_y,
  output logic [4:0] drug_x,
  output logic [4:0] drug_y,
  output logic       drug_on,
  output logic       eaten,
  output logic [7:0] score,
  output logic       place_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CHECK,
    ACTIVE
  } state_t;

  state_t     state;
  logic [3:0] retry_cnt;
  logic       cand_reject;
  logic       head_on_drug;

  // The body store is probed directly with the generator's current candidate.
  assign query_x = cand_x;
  assign query_y = cand_y;

  // A candidate is unusable if the body store flags it or the head sits on it.
  assign cand_reject  = query_occupied || ((cand_x == head_x) && (cand_y == head_y));
  assign head_on_drug = (head_x == drug_x) && (head_y == drug_y);

  // Placement FSM with registered outputs; game_over outranks one_start,
  // which outranks the normal state progression.
  // NOTE: nonblocking (<=) everywhere in this block so every register samples
  // the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      drug_valid <= 1'b0;
      drug_on    <= 1'b0;
      eaten      <= 1'b0;
      score      <= 8'd0;
      place_err  <= 1'b0;
      retry_cnt  <= 4'd0;
      drug_x     <= 5'd0;
      drug_y     <= 5'd0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only on the
      // transition that calls for them, so they can never stick high.
      eaten      <= 1'b0;
      drug_valid <= 1'b0;
      if (game_over) begin
        state   <= IDLE;
        drug_on <= 1'b0;
      end else if (one_start) begin
        state      <= REQ;
        drug_valid <= 1'b1;
        drug_on    <= 1'b0;
        score      <= 8'd0;
        place_err  <= 1'b0;
        retry_cnt  <= 4'd0;
      end else begin
        case (state)
          IDLE: ;
          REQ:  state <= WAIT;
          WAIT: state <= CHECK;
          CHECK: begin
            if (cand_reject) begin
              state      <= REQ;
              drug_valid <= 1'b1;
              if (retry_cnt == 4'd15) place_err <= 1'b1;
              else                    retry_cnt <= retry_cnt + 4'd1;
            end else begin
              drug_x    <= cand_x;
              drug_y    <= cand_y;
              retry_cnt <= 4'd0;
              drug_on   <= 1'b1;
              state     <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (head_step && head_on_drug) begin
              eaten      <= 1'b1;
              drug_on    <= 1'b0;
              drug_valid <= 1'b1;
              state      <= REQ;
              if (score != 8'hFF) score <= score + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_drug_placer.sv
// tb_drug_placer: directed stimulus for drug_placer with a cycle-level
// behavioural model, a per-cycle compare process and literal spot checks.
module tb_drug_placer;

  logic       clk = 1'b0;
  logic       rst;
  logic       one_start, game_over, head_step;
  logic [4:0] head_x, head_y;
  logic [4:0] cand_x, cand_y;
  logic       query_occupied;
  logic       drug_valid;
  logic [4:0] query_x, query_y, drug_x, drug_y;
  logic       drug_on, eaten, place_err;
  logic [7:0] score;

  int n_pass  = 0;
  int n_total = 0;

  drug_placer dut (
    .clk(clk), .rst(rst), .one_start(one_start), .game_over(game_over),
    .head_step(head_step), .head_x(head_x), .head_y(head_y),
    .cand_x(cand_x), .cand_y(cand_y), .query_occupied(query_occupied),
    .drug_valid(drug_valid), .query_x(query_x), .query_y(query_y),
    .drug_x(drug_x), .drug_y(drug_y), .drug_on(drug_on), .eaten(eaten),
    .score(score), .place_err(place_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------- environment: body store and random generator ----------
  bit         body [0:31][0:31];
  logic [9:0] cand_q [$];

  assign query_occupied = body[query_y][query_x];

  // Generator: next queued candidate appears after drug_valid is sampled high.
  always @(posedge clk) begin
    if (drug_valid && cand_q.size() > 0) begin
      cand_x <= cand_q[0][9:5];
      cand_y <= cand_q[0][4:0];
      cand_q.pop_front();
    end
  end

  // ---------------- behavioural model ----------------
  // m_phase counts cycles since the current request: 0 request, 1 generator
  // update, 2 decision, 3 drug on display.
  bit m_run;
  int m_phase, m_score, m_rejects;
  bit m_err, m_eat;
  int m_x, m_y;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_phase <= 0; m_score <= 0; m_rejects <= 0;
      m_err <= 0; m_eat <= 0; m_x <= 0; m_y <= 0;
    end else begin
      m_eat <= 0;
      if (game_over) m_run <= 0;
      else if (one_start) begin
        m_run <= 1; m_phase <= 0; m_score <= 0; m_err <= 0; m_rejects <= 0;
      end else if (m_run) begin
        if (m_phase == 0 || m_phase == 1) m_phase <= m_phase + 1;
        else if (m_phase == 2) begin
          if (body[cand_y][cand_x] || (cand_x == head_x && cand_y == head_y)) begin
            m_phase <= 0;
            if (m_rejects + 1 >= 16) m_err <= 1;
            m_rejects <= m_rejects + 1;
          end else begin
            m_x <= cand_x; m_y <= cand_y; m_rejects <= 0; m_phase <= 3;
          end
        end else if (head_step && head_x == m_x && head_y == m_y) begin
          m_eat <= 1; m_phase <= 0;
          m_score <= (m_score >= 255) ? 255 : m_score + 1;
        end
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    check("drug_valid", drug_valid, int'(m_run && m_phase == 0));
    check("drug_on",    drug_on,    int'(m_run && m_phase == 3));
    check("eaten",      eaten,      int'(m_eat));
    check("score",      score,      m_score);
    check("place_err",  place_err,  int'(m_err));
    check("drug_x",     drug_x,     m_x);
    check("drug_y",     drug_y,     m_y);
    check("query_x",    query_x,    cand_x);
    check("query_y",    query_y,    cand_y);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_drug_on(input string name, input int budget);
    int n = 0;
    while (!drug_on && n < budget) begin step(); n++; end
    if (!drug_on) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic eat_at(input logic [4:0] x, input logic [4:0] y);
    head_x = x; head_y = y; head_step = 1'b1;
    step();
    head_step = 1'b0; head_x = 5'd0; head_y = 5'd0;
  endtask

  initial begin
    int pulses, n;
    rst = 1'b1; one_start = 0; game_over = 0; head_step = 0;
    head_x = 0; head_y = 0;
    cand_x = 0; cand_y = 0;
    repeat (2) step();
    check("rst_drug_valid", drug_valid, 0);
    check("rst_score", score, 0);
    rst = 1'b0;
    repeat (3) step();
    check("idle_no_request", drug_valid, 0);

    // First-try placement at (8,8)
    cand_q.push_back({5'd8, 5'd8});
    one_start = 1'b1; step(); one_start = 1'b0;
    check("t1_req_valid", drug_valid, 1);
    step(); check("t1_wait_valid", drug_valid, 0);
    step(); check("t1_check_on", drug_on, 0);
    step();
    check("t1_active_on", drug_on, 1);
    check("t1_drug_x", drug_x, 8);
    check("t1_drug_y", drug_y, 8);

    // Head on the drug without a step never eats
    head_x = 8; head_y = 8; head_step = 0;
    repeat (2) step();
    check("nostep_eaten", eaten, 0);
    check("nostep_on", drug_on, 1);

    // Candidates for the next placement: three occupied, then (5,20)
    body[1][1] = 1; body[2][2] = 1; body[3][3] = 1;
    cand_q.push_back({5'd1, 5'd1}); cand_q.push_back({5'd2, 5'd2});
    cand_q.push_back({5'd3, 5'd3}); cand_q.push_back({5'd5, 5'd20});

    eat_at(5'd8, 5'd8);
    check("t2_eaten", eaten, 1);
    check("t2_score", score, 1);
    check("t2_on", drug_on, 0);
    check("t2_valid", drug_valid, 1);
    pulses = 1;
    step(); check("t2_eaten_once", eaten, 0);
    n = 0;
    while (!drug_on && n < 40) begin
      if (drug_valid) pulses++;
      step(); n++;
    end
    check("t3_timeout", int'(drug_on), 1);
    check("t3_pulses", pulses, 4);
    check("t3_drug_x", drug_x, 5);
    check("t3_drug_y", drug_y, 20);
    check("t3_err", place_err, 0);

    // Sixteen occupied candidates in a row
    for (int i = 0; i < 16; i++) begin
      body[i][10] = 1;
      cand_q.push_back({5'd10, 5'(i)});
    end
    eat_at(5'd5, 5'd20);
    check("t4_score", score, 2);
    pulses = 0; n = 0;
    while (n < 120) begin
      if (place_err) break;
      if (drug_valid) pulses++;
      step(); n++;
    end
    check("t4_err", place_err, 1);
    check("t4_pulses", pulses, 16);
    check("t4_on", drug_on, 0);
    cand_q.push_back({5'd12, 5'd12});
    one_start = 1'b1; step(); one_start = 1'b0;
    check("t4_err_cleared", place_err, 0);
    check("t4_score_cleared", score, 0);
    check("t4_restart_valid", drug_valid, 1);
    wait_drug_on("t4_place", 40);
    check("t4_drug_x", drug_x, 12);

    // Drive score to saturation; the generator keeps offering (12,12)
    for (int i = 1; i <= 256; i++) begin
      wait_drug_on("t5_place", 40);
      eat_at(5'd12, 5'd12);
      if (i == 1 || i == 255 || i == 256) begin
        check("t5_eaten", eaten, 1);
        check("t5_score", score, (i > 255) ? 255 : i);
      end
    end
    wait_drug_on("t5_last", 40);
    head_x = 12; head_y = 12; head_step = 1; game_over = 1;
    step();
    head_step = 0; game_over = 0; head_x = 0; head_y = 0;
    check("t5_go_eaten", eaten, 0);
    check("t5_go_score", score, 255);
    check("t5_go_on", drug_on, 0);
    check("t5_go_valid", drug_valid, 0);
    one_start = 1; game_over = 1; step(); one_start = 0; game_over = 0;
    repeat (3) step();
    check("t5_go_wins_start", drug_valid, 0);
    check("t5_score_held", score, 255);

    // Reset asserted during WAIT
    cand_q.push_back({5'd20, 5'd3});
    one_start = 1; step(); one_start = 0;
    step();
    rst = 1'b1; #1;
    check("t6_rst_valid", drug_valid, 0);
    check("t6_rst_on", drug_on, 0);
    check("t6_rst_score", score, 0);
    check("t6_rst_err", place_err, 0);
    check("t6_rst_drug_x", drug_x, 0);
    check("t6_rst_drug_y", drug_y, 0);
    step(); rst = 1'b0;
    pulses = 0;
    repeat (5) begin step(); if (drug_valid) pulses++; end
    check("t6_no_request", pulses, 0);
    one_start = 1; step(); one_start = 0;
    check("t6_start_valid", drug_valid, 1);
    wait_drug_on("t6_place", 40);
    check("t6_drug_x", drug_x, 20);
    check("t6_drug_y", drug_y, 3);

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
